// File: rtl/boot_sequencer.sv
// boot_sequencer: gathers per-source readiness, stretches the core reset
// release through a hold window, restarts on user reset, and keeps the
// cold-boot RAM address scramble counter.
// Optional feature macro: BOOT_SEQ_TIMEOUT_EN (optional sources may time out).
module boot_sequencer #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned CLK_HZ      = 32000000,
  parameter int unsigned TIMEOUT_MS  = 2000,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned SCRAMBLE_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SRC-1:0]    src_ready,
  input  logic [NUM_SRC-1:0]    src_optional,
  input  logic                  user_reset,
  input  logic                  coldboot,
  output logic                  resb,
  output logic [SCRAMBLE_W-1:0] scramble,
  output logic [NUM_SRC-1:0]    timed_out,
  output logic [1:0]            state
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_SRC = 2'd0,
    HOLD     = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  coldboot_q;
  logic [SCRAMBLE_W-1:0] scramble_q;
  logic [NUM_SRC-1:0]    satisfied;
  logic [NUM_SRC-1:0]    mandatory;
  logic                  all_sat;
  logic                  mand_drop;

`ifdef BOOT_SEQ_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int unsigned TIMER_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               timer_done;
  logic               timer_hit;
  logic [NUM_SRC-1:0] timed_out_q;

  assign timer_done = (timer_q == TIMER_MAX);
  assign mandatory  = ~src_optional;
  assign satisfied  = src_ready | (src_optional & {NUM_SRC{timer_done}});

  // Timer runs only in WAIT_SRC; parked at zero elsewhere so every re-entry
  // gives optional sources a full new timeout.
  always_comb begin
    timer_d   = '0;
    timer_hit = 1'b0;
    if (state_q == WAIT_SRC) begin
      if (timer_done) begin
        timer_d = timer_q;
      end else begin
        timer_d   = timer_q + TIMER_W'(1);
        timer_hit = (timer_d == TIMER_MAX);
      end
    end
  end

  // Timer register and sticky timeout flags, set on the edge the timer saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q     <= '0;
      timed_out_q <= '0;
    end else begin
      timer_q <= timer_d;
      if (timer_hit) begin
        timed_out_q <= timed_out_q | (src_optional & ~src_ready);
      end
    end
  end

  assign timed_out = timed_out_q;
`else
  logic unused_cfg;

  assign mandatory  = '1;
  assign satisfied  = src_ready;
  assign timed_out  = '0;
  assign unused_cfg = ^{src_optional, CLK_HZ[0], TIMEOUT_MS[0]};
`endif

  assign all_sat   = &satisfied;
  assign mand_drop = |(mandatory & ~src_ready);

  // State and hold counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_SRC;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state and hold counter logic; a mandatory drop outranks user reset.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      WAIT_SRC: begin
        if (all_sat && !user_reset) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      HOLD: begin
        if (mand_drop) begin
          state_d = WAIT_SRC;
        end else if (user_reset) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      RUN: begin
        if (mand_drop) begin
          state_d = WAIT_SRC;
        end else if (user_reset) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = WAIT_SRC;
        hold_d  = '0;
      end
    endcase
  end

  // Cold-boot rising-edge detector and scramble counter, active in any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coldboot_q <= 1'b0;
      scramble_q <= '0;
    end else begin
      coldboot_q <= coldboot;
      if (coldboot && !coldboot_q) begin
        scramble_q <= scramble_q + SCRAMBLE_W'(1);
      end
    end
  end

  assign scramble = scramble_q;
  assign state    = state_q;
  assign resb     = (state_q == RUN);

endmodule
